// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int DEFAULT_DATA_W = 8;
  localparam int STAT_W         = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid after last_idx, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // last_idx is visited last, so it carries the lowest priority
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_idx) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any && valid[cand_idx]) begin
        idx = cand_idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-requester saturating beat statistics are built when ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_wr_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy
`ifdef ARB_STATS_EN
  ,
  input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
  output logic [STAT_W-1:0]          stat_count
`endif
);

  localparam int                IDX_W     = $clog2(NUM_REQ);
  localparam int                BCNT_W    = $clog2(MAX_BURST) + 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  LAST_REQ  = IDX_W'(NUM_REQ - 1);

  arb_state_e        state, state_d;
  logic [IDX_W-1:0]  grant_idx, grant_idx_d;
  logic [IDX_W-1:0]  last_idx, last_idx_d;
  logic [IDX_W-1:0]  pick_base, pick_idx;
  logic [BCNT_W-1:0] beat_cnt, beat_cnt_d;
  logic              granted, owner_valid, xfer, release_gnt, pick_any;
  logic [NUM_REQ-1:0] owner_1h;
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  assign granted     = (state == ARB_GRANT);
  assign owner_valid = req_valid[grant_idx];
  assign xfer        = granted & owner_valid & ~fifo_full;
  assign release_gnt = granted & ((xfer & (beat_cnt == LAST_BEAT)) | ~owner_valid);
  assign owner_1h    = NUM_REQ'(1) << grant_idx;

  // On release the departing owner is already the lowest priority for the same-cycle regrant
  assign pick_base = granted ? grant_idx : last_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid    (req_valid),
    .last_idx (pick_base),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  assign busy         = granted;
  assign grant        = granted ? owner_1h : '0;
  assign req_ready    = (granted & ~fifo_full) ? owner_1h : '0;
  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = xfer ? data_arr[grant_idx] : '0;

  always_comb begin
    state_d     = state;
    grant_idx_d = grant_idx;
    last_idx_d  = last_idx;
    beat_cnt_d  = beat_cnt;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d     = ARB_GRANT;
          grant_idx_d = pick_idx;
          beat_cnt_d  = '0;
        end
      end
      ARB_GRANT: begin
        if (release_gnt) begin
          last_idx_d = grant_idx;
          beat_cnt_d = '0;
          if (pick_any) begin
            grant_idx_d = pick_idx;
          end else begin
            state_d = ARB_IDLE;
          end
        end else if (xfer) begin
          beat_cnt_d = beat_cnt + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      last_idx  <= LAST_REQ;
      beat_cnt  <= '0;
    end else begin
      state     <= state_d;
      grant_idx <= grant_idx_d;
      last_idx  <= last_idx_d;
      beat_cnt  <= beat_cnt_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer && (grant_idx == IDX_W'(i)) && (stat_cnt[i] != '1)) begin
          stat_cnt[i] <= stat_cnt[i] + 1'b1;
        end
      end
      stat_count <= (int'(stat_sel) < NUM_REQ) ? stat_cnt[stat_sel] : '0;
    end
  end
`else
  // Arbitration-only build: no statistics state.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;
  localparam int EW = 2*N + 2 + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          fifo_full = 1'b0;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic [N-1:0]  grant;
  logic          busy;
`ifdef ARB_STATS_EN
  logic [IW-1:0] stat_sel = '0;
  logic [15:0]   stat_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant        (grant),
    .busy         (busy)
`ifdef ARB_STATS_EN
    ,
    .stat_sel     (stat_sel),
    .stat_count   (stat_count)
`endif
  );

  // Producers: each holds a queue of pending bytes and may withhold valid via en_mask.
  logic [7:0] src_q [N][$];
  logic [N-1:0] en_mask = '1;
  logic [7:0] wr_log [$];
  int         wr_cyc [$];
  int         cyc = 0;

  // Reference model: owner (-1 when nobody holds the port), last owner, beats in tenure.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_beats = 0;

  function automatic int rr_after(int last, logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[IW'((last + k) % N)]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [EW-1:0] model_expect();
    logic [N-1:0]  g = '0;
    logic [N-1:0]  r = '0;
    logic          b = 1'b0;
    logic          w = 1'b0;
    logic [DW-1:0] d = '0;
    if (m_owner >= 0) begin
      g = N'(1) << m_owner;
      b = 1'b1;
      if (!fifo_full) r = g;
      w = !fifo_full && req_valid[IW'(m_owner)];
      if (w) d = src_q[m_owner][0];
    end
    return {g, r, b, w, d};
  endfunction

  function automatic logic [EW-1:0] observed();
    return {grant, req_ready, busy, fifo_wr_en, (fifo_wr_en ? fifo_wr_data : {DW{1'b0}})};
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[IW'(i)]    = en_mask[IW'(i)] && (src_q[i].size() > 0);
      req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  task automatic model_step();
    logic w;
    w = (m_owner >= 0) && !fifo_full && req_valid[IW'(m_owner)];
    if (fifo_wr_en) begin
      wr_log.push_back(fifo_wr_data);
      wr_cyc.push_back(cyc);
    end
    if (w) begin
      void'(src_q[m_owner].pop_front());
      m_beats++;
    end
    if (m_owner < 0) begin
      if (req_valid != '0) begin
        m_owner = rr_after(m_last, req_valid);
        m_beats = 0;
      end
    end else if (m_beats == MB || !req_valid[IW'(m_owner)]) begin
      m_last  = m_owner;
      m_beats = 0;
      m_owner = (req_valid != '0) ? rr_after(m_owner, req_valid) : -1;
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_beats = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    en_mask   = '1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    wr_log.delete();
    wr_cyc.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    logic [EW-1:0] obs;
    logic [EW-1:0] exp_v;
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = $urandom();
    fifo_full = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      obs = observed();
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL reset_hold%0d: got %h want %h", k, obs, {EW{1'b0}});
      end
    end
    req_valid = '0;
    rst_n     = 1'b1;
    #2;
    obs = observed();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got %h want %h", obs, {EW{1'b0}});
    end
    @(posedge clk);
    #1;
    req_valid = 4'b0101;
    #2;
    obs = observed();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_arb_latency: got %h want %h", obs, {EW{1'b0}});
    end
    @(posedge clk);
    #1;
    exp_v = {4'b0001, 4'b0001, 1'b1, 1'b1, req_data[7:0]};
    obs = observed();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL reset_first_pick: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_single();
    logic [EW-1:0] obs, exp_v;
    do_reset();
    for (int k = 0; k < 10; k++) src_q[0].push_back(8'(8'h10 + k));
    for (int c = 0; c < 13; c++) begin
      apply_inputs();
      #2;
      exp_v = model_expect();
      obs   = observed();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL single_cyc%0d: got %h want %h", c, obs, exp_v);
      end
      model_step();
      @(posedge clk);
      #1;
      cyc++;
    end
    vectors++;
    if (wr_log.size() != 10) begin
      miscompares++;
      $display("FAIL single_count: got %0d writes want 10", wr_log.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        vectors++;
        if (wr_log[k] !== 8'(8'h10 + k) || wr_cyc[k] != k + 1) begin
          miscompares++;
          $display("FAIL single_beat%0d: got %h@%0d want %h@%0d", k, wr_log[k], wr_cyc[k], 8'(8'h10 + k), k + 1);
        end
      end
    end
  endtask

  task automatic test_all_four();
    logic [EW-1:0] obs, exp_v;
    logic [7:0]    want;
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) src_q[i].push_back(8'(8'hA0 + 16*i + j));
    for (int c = 0; c < 35; c++) begin
      apply_inputs();
      #2;
      exp_v = model_expect();
      obs   = observed();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL all_four_cyc%0d: got %h want %h", c, obs, exp_v);
      end
      model_step();
      @(posedge clk);
      #1;
      cyc++;
    end
    vectors++;
    if (wr_log.size() != 32) begin
      miscompares++;
      $display("FAIL all_four_count: got %0d writes want 32", wr_log.size());
    end else begin
      for (int k = 0; k < 32; k++) begin
        want = 8'(8'hA0 + 16*((k % 16) / 4) + 4*(k / 16) + (k % 4));
        vectors++;
        if (wr_log[k] !== want || wr_cyc[k] != k + 1) begin
          miscompares++;
          $display("FAIL all_four_beat%0d: got %h@%0d want %h@%0d", k, wr_log[k], wr_cyc[k], want, k + 1);
        end
      end
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    stat_sel = 2'd2;
    @(posedge clk);
    #1;
    vectors++;
    if (stat_count !== 16'd8) begin
      miscompares++;
      $display("FAIL stats_req2: got %0d want 8", stat_count);
    end
    stat_sel = 2'd1;
    @(posedge clk);
    #1;
    vectors++;
    if (stat_count !== 16'd8) begin
      miscompares++;
      $display("FAIL stats_req1: got %0d want 8", stat_count);
    end
    req_valid = 4'b0001;
    fifo_full = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    req_valid = '0;
    stat_sel  = 2'd0;
    @(posedge clk);
    #1;
    vectors++;
    if (stat_count !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL stats_saturate: got %h want ffff", stat_count);
    end
  endtask
`endif

  task automatic test_backpressure();
    logic [EW-1:0] obs, exp_v;
    int            wc;
    do_reset();
    for (int k = 0; k < 4; k++) src_q[2].push_back(8'(8'hC0 + k));
    for (int c = 0; c < 11; c++) begin
      fifo_full = (c >= 2 && c <= 5);
      apply_inputs();
      #2;
      exp_v = model_expect();
      obs   = observed();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL backpressure_cyc%0d: got %h want %h", c, obs, exp_v);
      end
      model_step();
      @(posedge clk);
      #1;
      cyc++;
    end
    fifo_full = 1'b0;
    vectors++;
    if (wr_log.size() != 4) begin
      miscompares++;
      $display("FAIL backpressure_count: got %0d writes want 4", wr_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        wc = (k == 0) ? 1 : k + 5;
        vectors++;
        if (wr_log[k] !== 8'(8'hC0 + k) || wr_cyc[k] != wc) begin
          miscompares++;
          $display("FAIL backpressure_beat%0d: got %h@%0d want %h@%0d", k, wr_log[k], wr_cyc[k], 8'(8'hC0 + k), wc);
        end
      end
    end
  endtask

  task automatic test_early_release();
    logic [EW-1:0] obs, exp_v;
    logic [7:0]    exp_seq [8];
    exp_seq = '{8'h10, 8'h11, 8'h30, 8'h31, 8'h32, 8'h33, 8'h12, 8'h13};
    do_reset();
    src_q[1].push_back(8'h10);
    src_q[1].push_back(8'h11);
    for (int k = 0; k < 4; k++) src_q[3].push_back(8'(8'h30 + k));
    for (int c = 0; c < 13; c++) begin
      if (c == 4) begin
        src_q[1].push_back(8'h12);
        src_q[1].push_back(8'h13);
      end
      apply_inputs();
      #2;
      exp_v = model_expect();
      obs   = observed();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL early_release_cyc%0d: got %h want %h", c, obs, exp_v);
      end
      model_step();
      @(posedge clk);
      #1;
      cyc++;
    end
    vectors++;
    if (wr_log.size() != 8) begin
      miscompares++;
      $display("FAIL early_release_count: got %0d writes want 8", wr_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        vectors++;
        if (wr_log[k] !== exp_seq[k]) begin
          miscompares++;
          $display("FAIL early_release_beat%0d: got %h want %h", k, wr_log[k], exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] obs, exp_v;
    logic [7:0]    exp_seq [12];
    exp_seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                8'h80, 8'h81, 8'h82, 8'h83, 8'h06, 8'h07};
    do_reset();
    for (int k = 0; k < 8; k++) src_q[0].push_back(8'(k));
    for (int k = 0; k < 4; k++) src_q[1].push_back(8'(8'h80 + k));
    for (int c = 0; c < 4; c++) begin
      apply_inputs();
      #2;
      exp_v = model_expect();
      obs   = observed();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reset_mid_pre_cyc%0d: got %h want %h", c, obs, exp_v);
      end
      if (c == 3) break;
      model_step();
      @(posedge clk);
      #1;
      cyc++;
    end
    // Beat 3 of requester 0 is on the port: pull reset before the edge.
    #1;
    rst_n = 1'b0;
    #1;
    obs = observed();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got %h want %h", obs, {EW{1'b0}});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 16; c++) begin
      apply_inputs();
      #2;
      exp_v = model_expect();
      obs   = observed();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reset_mid_post_cyc%0d: got %h want %h", c, obs, exp_v);
      end
      model_step();
      @(posedge clk);
      #1;
      cyc++;
    end
    vectors++;
    if (wr_log.size() != 12) begin
      miscompares++;
      $display("FAIL reset_mid_count: got %0d writes want 12", wr_log.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        vectors++;
        if (wr_log[k] !== exp_seq[k]) begin
          miscompares++;
          $display("FAIL reset_mid_beat%0d: got %h want %h", k, wr_log[k], exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [EW-1:0] obs, exp_v;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0 && src_q[i].size() < 7) src_q[i].push_back(8'($urandom()));
      end
      en_mask   = N'($urandom()) | N'($urandom());
      fifo_full = ($urandom_range(0, 3) == 0);
      apply_inputs();
      #2;
      exp_v = model_expect();
      obs   = observed();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL random_cyc%0d: got %h want %h", c, obs, exp_v);
      end
      model_step();
      @(posedge clk);
      #1;
      cyc++;
    end
    fifo_full = 1'b0;
    en_mask   = '1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    test_backpressure();
    test_early_release();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
